// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package sync_fifo_pkg;

   localparam int DefaultWidth = 32;
   localparam int DefaultDepth = 16;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM with a synchronous write port and a registered read port.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DefaultWidth,
   parameter int DEPTH = DefaultDepth,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;

   // Storage carries no reset so it can map onto a plain RAM macro.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dout_q <= '0;
      end else if (re_i) begin
         dout_q <= mem_q[raddr_i];
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, acceptance and flag logic around a dual-port RAM.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DefaultWidth,
   parameter int DEPTH = DefaultDepth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rdOk, wrOk;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FullCount);

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rdOk = rd_en & ~empty_o;
   assign wrOk = wr_en & (~full_o | rdOk);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (wrOk) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rdOk) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({wrOk, rdOk})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Reset wins over any request, so the RAM ports are masked while it is high.
   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wrOk & ~rst_i),
      .waddr_i (wrPtr_q),
      .wdata_i (data_i),
      .re_i    (rdOk & ~rst_i),
      .raddr_i (rdPtr_q),
      .dout_o  (data_o)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus queues expected outputs, a monitor pops and compares them.
module tb_sync_fifo;

   typedef struct {
      logic [31:0] data;
      logic        empty;
      logic        full;
   } expEntry_t;

   logic        clk;
   logic        rst_i;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        full_o;
   logic        empty_o;

   expEntry_t   expQ[$];
   logic [31:0] model[$];
   logic [31:0] lastData;
   int          testsRun;
   int          testsFailed;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (16)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .data_i  (data_i),
      .data_o  (data_o),
      .full_o  (full_o),
      .empty_o (empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drives one cycle and queues the outputs a behavioural FIFO predicts after that edge.
   task automatic applyStimulus(input logic rst, input logic wr, input logic rd, input logic [31:0] d);
      expEntry_t e;
      logic      rdAcc;
      logic      wrAcc;
      @(negedge clk);
      rst_i  = rst;
      wr_en  = wr;
      rd_en  = rd;
      data_i = d;
      if (rst) begin
         model.delete();
         lastData = '0;
      end else begin
         rdAcc = rd && (model.size() != 0);
         wrAcc = wr && ((model.size() < 16) || rdAcc);
         if (rdAcc) lastData = model.pop_front();
         if (wrAcc) model.push_back(d);
      end
      e.data  = lastData;
      e.empty = (model.size() == 0);
      e.full  = (model.size() == 16);
      expQ.push_back(e);
      @(posedge clk);
   endtask

   always @(posedge clk) begin
      expEntry_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("data_o", data_o, e.data);
         checkOutput("empty_o", {31'b0, empty_o}, {31'b0, e.empty});
         checkOutput("full_o", {31'b0, full_o}, {31'b0, e.full});
      end
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      lastData    = '0;
      rst_i       = 1'b1;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      data_i      = '0;

      // Reset, then reads on an empty FIFO must not disturb anything.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("reset empty_o", {31'b0, empty_o}, 32'h1);
      checkOutput("reset full_o", {31'b0, full_o}, 32'h0);
      checkOutput("reset data_o", data_o, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("empty read data_o", data_o, 32'h0);

      // Fill past capacity; writes 17-20 are dropped.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h100 + i);
         #2;
         if (i == 14) checkOutput("full after 15 writes", {31'b0, full_o}, 32'h0);
         if (i == 15) checkOutput("full after 16 writes", {31'b0, full_o}, 32'h1);
      end

      // Drain past empty; data_o holds the last word.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
         #2;
         if (i == 0) checkOutput("first drained word", data_o, 32'h100);
         if (i == 14) checkOutput("empty after 15 reads", {31'b0, empty_o}, 32'h0);
         if (i == 15) checkOutput("empty after 16 reads", {31'b0, empty_o}, 32'h1);
      end
      checkOutput("drain hold data_o", data_o, 32'h10F);

      // Wrap-around of both pointers.
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h200 + i);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h300 + i);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("wrap last word", data_o, 32'h30F);

      // Simultaneous read/write while full pops the oldest words.
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h500 + i);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 32'h400 + i);
         #2;
         checkOutput("full simultaneous pop", data_o, 32'h500 + i);
         checkOutput("full stays high", {31'b0, full_o}, 32'h1);
      end
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("after full sim drain", data_o, 32'h403);

      // Simultaneous read/write while empty: no fall-through.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hA5);
      #2;
      checkOutput("empty sim data_o held", data_o, 32'h403);
      checkOutput("empty sim empty_o", {31'b0, empty_o}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("A5 readback", data_o, 32'hA5);

      // Random traffic, then a mid-stream reset.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h600 + i);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD);
      #2;
      checkOutput("mid reset empty_o", {31'b0, empty_o}, 32'h1);
      checkOutput("mid reset data_o", data_o, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("no stale data", data_o, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h777);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      #2;
      checkOutput("post reset word", data_o, 32'h777);

      @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
